// File: rtl/if_fetch_pkg.sv
// Shared pipeline constants and IF/ID payload type for the fetch stage.
package if_fetch_pkg;

  localparam int unsigned InstAddrW = 32;
  localparam int unsigned InstW     = 32;
  localparam int unsigned StallW    = 6;

  // Stall vector bit positions used by the fetch stage
  localparam int unsigned StallPcBit = 0;
  localparam int unsigned StallIfBit = 1;
  localparam int unsigned StallIdBit = 2;

  typedef logic [InstAddrW-1:0] inst_addr_t;
  typedef logic [InstW-1:0]     inst_t;

  localparam logic Stop        = 1'b1;
  localparam logic NoStop      = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnable   = 1'b1;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam inst_addr_t  ResetPC  = 32'h0000_0000;

  // IF/ID pipeline register payload
  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_id_t;

endpackage : if_fetch_pkg

// File: rtl/if_id.sv
// IF/ID pipeline register carrying fetched instruction and its PC to decode.
// Ports: clk, rst (sync, active-high), flush_i (bubble), stall_if_i/stall_id_i
//        (controller stall bits), pc_i/inst_i (fetch result),
//        id_pc_o/id_inst_o (to decode; zero instruction is a bubble).
module if_id
  import if_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       stall_if_i,
  input  logic       stall_id_i,
  input  inst_addr_t pc_i,
  input  inst_t      inst_i,
  output inst_addr_t id_pc_o,
  output inst_t      id_inst_o
);

  if_id_t payload_q, payload_d;

  // IF held while ID runs: feed a bubble so ID does not execute twice
  always_comb begin
    payload_d = payload_q;
    if (flush_i) begin
      payload_d = '0;
    end else if ((stall_if_i == Stop) && (stall_id_i == NoStop)) begin
      payload_d = '0;
    end else if (stall_if_i == NoStop) begin
      payload_d.pc   = pc_i;
      payload_d.inst = inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      payload_q <= '0;
    end else begin
      payload_q <= payload_d;
    end
  end

  assign id_pc_o   = payload_q.pc;
  assign id_inst_o = payload_q.inst;

endmodule : if_id

// File: rtl/pc_reg.sv
// Program counter and ROM chip-enable register.
// Ports: clk, rst (sync, active-high), flush_i/new_pc_i (exception redirect),
//        stall_pc_i (hold PC), branch_flag_i/branch_target_i (ID redirect),
//        ce_o (ROM enable), pc_o (fetch address).
module pc_reg
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = ResetPC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  inst_addr_t new_pc_i,
  input  logic       stall_pc_i,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  output logic       ce_o,
  output inst_addr_t pc_o
);

  logic       ce_q;
  inst_addr_t pc_q, pc_d;

  // Next PC: disabled > flush > stall > branch > sequential
  always_comb begin
    pc_d = pc_q;
    if (ce_q == ChipDisable) begin
      pc_d = RESET_PC;
    end else if (flush_i) begin
      pc_d = new_pc_i;
    end else if (stall_pc_i == Stop) begin
      pc_d = pc_q;
    end else if (branch_flag_i) begin
      pc_d = branch_target_i;
    end else begin
      pc_d = pc_q + InstAddrW'(PC_STEP);
    end
  end

  // Reset also forces the PC so a pending redirect is discarded immediately
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      ce_q <= ChipDisable;
      pc_q <= RESET_PC;
    end else begin
      ce_q <= ChipEnable;
      pc_q <= pc_d;
    end
  end

  assign ce_o = ce_q;
  assign pc_o = pc_q;

endmodule : pc_reg

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC/enable register plus IF/ID pipeline register.
// Ports: clk, rst (sync, active-high), stall_i[5:0] (bits 0..2 used),
//        flush_i/new_pc_i, branch_flag_i/branch_target_i, inst_i (ROM data),
//        ce_o/pc_o (ROM enable/address), id_pc_o/id_inst_o (to decode).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = ResetPC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [StallW-1:0] stall_i,
  input  logic              flush_i,
  input  inst_addr_t        new_pc_i,
  input  logic              branch_flag_i,
  input  inst_addr_t        branch_target_i,
  input  inst_t             inst_i,
  output logic              ce_o,
  output inst_addr_t        pc_o,
  output inst_addr_t        id_pc_o,
  output inst_t             id_inst_o
);

  // Later-stage stall bits are not relevant to fetch
  logic unused_stall;
  assign unused_stall = ^stall_i[StallW-1:StallIdBit+1];

  pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .stall_pc_i      (stall_i[StallPcBit]),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .ce_o            (ce_o),
    .pc_o            (pc_o)
  );

  if_id u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .stall_if_i (stall_i[StallIfBit]),
    .stall_id_i (stall_i[StallIdBit]),
    .pc_i       (pc_o),
    .inst_i     (inst_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );

endmodule : if_fetch

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter and drives the chip-enable and address of the combinational instruction ROM. It also latches the returned instruction together with its PC into the IF/ID pipeline register for the decode stage. It honours the pipeline controller's stall vector, ID-stage branch redirects (with MIPS delay-slot semantics) and exception flushes.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value while disabled and after reset.
- `PC_STEP`, default `4`: sequential PC increment in bytes.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high (`RstEnable`).
- `stall_i`  in  6: controller stall vector, `Stop`/`NoStop` per bit. Bit0 holds PC, bit1 holds IF, bit2 holds ID. Bits 5:3 are ignored here.
- `flush_i`  in  1: exception flush from the controller.
- `new_pc_i`  in  32: exception handler address, used when `flush_i`.
- `branch_flag_i`  in  1: taken branch/jump resolved in ID.
- `branch_target_i`  in  32: redirect address, used when `branch_flag_i`.
- `inst_i`  in  `InstBus`: instruction from the ROM for the current `pc_o`.
- `ce_o`  out  1: ROM chip enable (`ChipEnable`/`ChipDisable`), registered.
- `pc_o`  out  `InstAddrBus`: fetch address to the ROM, registered.
- `id_pc_o`  out  `InstAddrBus`: PC of the instruction handed to ID.
- `id_inst_o`  out  `InstBus`: instruction handed to ID; `ZeroWord` is a bubble (nop).

## Operation
- Enable register:
  - `rst` high: `ce_o <= ChipDisable`.
  - Otherwise: `ce_o <= ChipEnable`.
- PC register. Evaluate in priority order; the first matching rule applies.
  1. `ce_o == ChipDisable`: `pc_o <= RESET_PC`.
  2. `flush_i`: `pc_o <= new_pc_i`.
  3. `stall_i[0] == Stop`: hold.
  4. `branch_flag_i`: `pc_o <= branch_target_i`.
  5. Otherwise: `pc_o <= pc_o + PC_STEP`, modulo 2^32; wraps `32'hFFFF_FFFC -> 0`.
- Delay slot: the instruction fetched in the cycle `branch_flag_i` is high is latched into IF/ID normally and is not squashed.
- IF/ID register. Evaluate in priority order; the first matching rule applies.
  1. `rst`: `id_pc_o <= ZeroWord`, `id_inst_o <= ZeroWord`.
  2. `flush_i`: load zeros (bubble).
  3. `stall_i[1] == Stop` and `stall_i[2] == NoStop`: load zeros. This inserts a bubble while IF is held.
  4. `stall_i[1] == NoStop`: `id_pc_o <= pc_o`, `id_inst_o <= inst_i`.
  5. Otherwise (IF and ID both stalled): hold.
- No alignment checking: `pc_o[1:0]` is passed through unmodified; alignment exceptions belong to ID/MEM.
- Reset mid-operation: the next edge with `rst` forces all outputs to their reset values and discards any pending branch or flush.

## Timing
- Reset values: `ce_o = 0`, `pc_o = RESET_PC`, `id_pc_o = 0`, `id_inst_o = 0`.
- First edge after `rst` falls: `ce_o` goes to 1 while `pc_o` stays `RESET_PC`. The next edge advances `pc_o` to `RESET_PC + 4`.
- The ROM is combinational, so `inst_i` is valid in the same cycle as `pc_o`. The fetch-to-ID latency is 1 cycle.
- Redirect latency is 1 edge for both branch and flush.
- A branch asserted during `stall_i[0]` is lost. The controller guarantees that ID re-asserts `branch_flag_i` after the stall.
- If flush and stall are asserted together, the flush wins.

## Structure
- `Stop`, `NoStop`, `ChipEnable`, `ChipDisable`, `RstEnable`, `ZeroWord`, `InstAddrBus` and `InstBus` come from the shared `defines.v`. Add `ResetPC` there and default `RESET_PC` to it.
- Split into two sub-modules:
  - `pc_reg`: enable and PC register.
  - `if_id`: pipeline register.
- The top level only wires them together.

## Test plan
- Reset release with no stall: `pc_o` sequence is 0, 0, 4, 8, 0xC, and `ce_o` goes 0→1 one edge after `rst` falls. The ROM is loaded with 0x34011100, 0x34020020, …. `id_inst_o` must show 0x34011100 then 0x34020020, with `id_pc_o` equal to 0 then 4.
- Stall: with `stall_i = 6'b000011` for 2 cycles at `pc_o = 8`, `pc_o` holds 8 and `id_inst_o = 0` (bubble). Fetch resumes at 8 afterwards.
- Stall `6'b000111`: `pc_o` and both IF/ID outputs hold their prior values.
- Branch: `branch_flag_i = 1` with target 0x40 at `pc_o = 0x10`. The next `pc_o` is 0x40, and the 0x10 instruction (delay slot) reaches `id_inst_o` unsquashed.
- Flush during a branch: `flush_i = 1`, `new_pc_i = 0x20`, `branch_flag_i = 1`, target 0x40. Result is `pc_o = 0x20` and `id_inst_o = 0`, `id_pc_o = 0`.
- Wrap and reset mid-run:
  - From `pc_o = 0xFFFFFFFC`, the next `pc_o` is 0.
  - Asserting `rst` at any point gives `ce_o = 0` and all outputs 0 on the next edge.
